// File: rtl/cache_bus_arbiter.sv
// Burst-level arbiter sharing one refill/writeback bus between NREQ cache masters.
// Define CACHE_BUS_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (index 0 highest).
module cache_bus_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        m_req_valid_i,
  output logic [NREQ-1:0]        m_req_ready_o,
  input  logic [NREQ-1:0]        m_req_write_i,
  input  logic [NREQ*ADDR_W-1:0] m_req_addr_i,
  input  logic [NREQ*LEN_W-1:0]  m_req_len_i,
  input  logic [NREQ*DATA_W-1:0] m_wdata_i,
  input  logic [NREQ-1:0]        m_wvalid_i,
  output logic [NREQ-1:0]        m_wready_o,
  output logic [DATA_W-1:0]      m_rdata_o,
  output logic [NREQ-1:0]        m_rvalid_o,
  output logic                   m_rlast_o,
  output logic [NREQ-1:0]        bus_busy_o,
  output logic                   bus_req_valid_o,
  input  logic                   bus_req_ready_i,
  output logic                   bus_req_write_o,
  output logic [ADDR_W-1:0]      bus_req_addr_o,
  output logic [LEN_W-1:0]       bus_req_len_o,
  output logic [DATA_W-1:0]      bus_wdata_o,
  output logic                   bus_wvalid_o,
  output logic                   bus_wlast_o,
  input  logic                   bus_wready_i,
  input  logic [DATA_W-1:0]      bus_rdata_i,
  input  logic                   bus_rvalid_i,
  input  logic                   bus_rlast_i
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WDATA, S_RDATA} state_t;

  state_t            state_q;
  logic [GW-1:0]     grant_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt_q;
`ifdef CACHE_BUS_ARB_RR_EN
  logic [GW-1:0]     rr_ptr_q;
`endif

  logic              win_valid;
  logic [GW-1:0]     win_idx;
  logic              cur_write;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  cur_len;
  logic [DATA_W-1:0] cur_wdata;
  logic              req_hs;
  logic              w_hs;
  logic              wlast;
  logic              burst_done;

  assign cur_write = m_req_write_i[grant_q];
  assign cur_addr  = m_req_addr_i[int'(grant_q)*ADDR_W +: ADDR_W];
  assign cur_len   = m_req_len_i[int'(grant_q)*LEN_W +: LEN_W];
  assign cur_wdata = m_wdata_i[int'(grant_q)*DATA_W +: DATA_W];

  assign req_hs     = (state_q == S_ADDR) && m_req_valid_i[grant_q] && bus_req_ready_i;
  assign w_hs       = (state_q == S_WDATA) && m_wvalid_i[grant_q] && bus_wready_i;
  assign wlast      = (beat_cnt_q == len_q);
  assign burst_done = (w_hs && wlast) ||
                      ((state_q == S_RDATA) && bus_rvalid_i && bus_rlast_i);

  // Descending scan so the last hit is the candidate closest to the search start.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
`ifdef CACHE_BUS_ARB_RR_EN
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (m_req_valid_i[(int'(rr_ptr_q) + off) % NREQ]) begin
        win_valid = 1'b1;
        win_idx   = GW'((int'(rr_ptr_q) + off) % NREQ);
      end
    end
`else
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (m_req_valid_i[i]) begin
        win_valid = 1'b1;
        win_idx   = GW'(i);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
`ifdef CACHE_BUS_ARB_RR_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_valid) begin
            grant_q <= win_idx;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (req_hs) begin
            len_q      <= cur_len;
            beat_cnt_q <= '0;
            state_q    <= cur_write ? S_WDATA : S_RDATA;
          end
        end
        S_WDATA: begin
          if (w_hs) beat_cnt_q <= beat_cnt_q + 1'b1;
        end
        default: ;
      endcase
      if (burst_done) begin
        state_q  <= S_IDLE;
`ifdef CACHE_BUS_ARB_RR_EN
        rr_ptr_q <= (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
`endif
      end
    end
  end

  // Routing is gated by state so nothing leaks to or from a non-granted master.
  always_comb begin
    m_req_ready_o   = '0;
    m_wready_o      = '0;
    m_rdata_o       = '0;
    m_rvalid_o      = '0;
    m_rlast_o       = 1'b0;
    bus_req_valid_o = 1'b0;
    bus_req_write_o = 1'b0;
    bus_req_addr_o  = '0;
    bus_req_len_o   = '0;
    bus_wdata_o     = '0;
    bus_wvalid_o    = 1'b0;
    bus_wlast_o     = 1'b0;
    case (state_q)
      S_ADDR: begin
        bus_req_valid_o        = m_req_valid_i[grant_q];
        bus_req_write_o        = cur_write;
        bus_req_addr_o         = cur_addr;
        bus_req_len_o          = cur_len;
        m_req_ready_o[grant_q] = bus_req_ready_i;
      end
      S_WDATA: begin
        bus_wdata_o         = cur_wdata;
        bus_wvalid_o        = m_wvalid_i[grant_q];
        bus_wlast_o         = wlast;
        m_wready_o[grant_q] = bus_wready_i;
      end
      S_RDATA: begin
        m_rdata_o           = bus_rdata_i;
        m_rvalid_o[grant_q] = bus_rvalid_i;
        m_rlast_o           = bus_rlast_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus_busy_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus_busy_o[i] = (state_q != S_IDLE) && (grant_q != GW'(i));
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Randomized bench for cache_bus_arbiter: two master drivers, a downstream slave and
// a transaction-level ownership model that predicts every routed output each cycle.
module tb_cache_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_req_valid, m_req_ready, m_req_write, m_wvalid, m_wready, m_rvalid, bus_busy;
  logic [63:0] m_req_addr, m_wdata;
  logic [15:0] m_req_len;
  logic [31:0] m_rdata;
  logic        m_rlast;
  logic        bus_req_valid, bus_req_ready, bus_req_write;
  logic [31:0] bus_req_addr, bus_wdata, bus_rdata;
  logic [7:0]  bus_req_len;
  logic        bus_wvalid, bus_wlast, bus_wready, bus_rvalid, bus_rlast;
  logic [11:0] ctrl;

  always #5 clk = ~clk;

  cache_bus_arbiter #(.NREQ(2), .ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_valid_i(m_req_valid), .m_req_ready_o(m_req_ready), .m_req_write_i(m_req_write),
    .m_req_addr_i(m_req_addr), .m_req_len_i(m_req_len), .m_wdata_i(m_wdata),
    .m_wvalid_i(m_wvalid), .m_wready_o(m_wready), .m_rdata_o(m_rdata),
    .m_rvalid_o(m_rvalid), .m_rlast_o(m_rlast), .bus_busy_o(bus_busy),
    .bus_req_valid_o(bus_req_valid), .bus_req_ready_i(bus_req_ready),
    .bus_req_write_o(bus_req_write), .bus_req_addr_o(bus_req_addr), .bus_req_len_o(bus_req_len),
    .bus_wdata_o(bus_wdata), .bus_wvalid_o(bus_wvalid), .bus_wlast_o(bus_wlast),
    .bus_wready_i(bus_wready), .bus_rdata_i(bus_rdata), .bus_rvalid_i(bus_rvalid),
    .bus_rlast_i(bus_rlast)
  );

  assign ctrl = {m_req_ready, m_wready, m_rvalid, m_rlast, bus_busy,
                 bus_req_valid, bus_wvalid, bus_wlast};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Master drivers: 0 idle, 1 requesting, 2 sending write beats, 3 awaiting read beats
  int          mst_st[2];
  logic [31:0] mst_addr[2];
  logic [7:0]  mst_len[2];
  logic        mst_wr[2];
  int          mst_beat[2];
  logic [31:0] mst_wd[2];
  logic        mst_wv[2];
  int          slv_left;
  logic        slv_rv;
  int          req_pct, rdy_pct;
  int          bursts_done = 0;

  // Reference model: who owns the bus and which part of the burst it is in
  int          own;     // -1 when the bus is free
  int          part;    // 1 address, 2 write beats, 3 read beats
  int          mbeat;
  int          mlen;
  int          rr;
  logic        post_reset;

  function automatic int pick(input logic [1:0] reqv, input int start);
    for (int k = 0; k < 2; k++)
      if (reqv[(start + k) % 2]) return (start + k) % 2;
    return -1;
  endfunction

  task automatic reset_all();
    for (int i = 0; i < 2; i++) begin
      mst_st[i] = 0; mst_wv[i] = 1'b0; mst_beat[i] = 0;
    end
    slv_left = 0; slv_rv = 1'b0;
    own = -1; part = 0; mbeat = 0; mlen = 0; rr = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (mst_st[i] == 0 && ($urandom % 100) < req_pct) begin
        mst_st[i]   = 1;
        mst_addr[i] = $urandom;
        mst_len[i]  = (($urandom % 4) == 0) ? 8'($urandom % 8) : 8'($urandom % 2);
        mst_wr[i]   = 1'($urandom);
      end
      if (mst_st[i] == 2 && !mst_wv[i] && ($urandom % 100) < 70) begin
        mst_wv[i] = 1'b1;
        mst_wd[i] = $urandom;
      end
      m_req_valid[i]          = (mst_st[i] == 1);
      m_req_write[i]          = mst_wr[i];
      m_req_addr[i*32 +: 32]  = mst_addr[i];
      m_req_len[i*8 +: 8]     = mst_len[i];
      m_wvalid[i]             = (mst_st[i] == 2) && mst_wv[i];
      m_wdata[i*32 +: 32]     = mst_wd[i];
    end
    if (slv_left > 0 && !slv_rv && ($urandom % 100) < 60) slv_rv = 1'b1;
    bus_req_ready = ($urandom % 100) < rdy_pct;
    bus_wready    = ($urandom % 100) < rdy_pct;
    bus_rvalid    = slv_rv;
    bus_rlast     = slv_rv && (slv_left == 1);
    bus_rdata     = $urandom;
  endtask

  task automatic check_cycle();
    logic [1:0] exp_busy, exp_rdy, exp_wr, exp_rv;
    logic       exp_rqv, exp_wv;
    if (post_reset) chk("rst_ctrl", 64'(ctrl), 64'd0);
    exp_busy = (own < 0) ? 2'b00 : (2'b11 & ~(2'b01 << own));
    exp_rqv  = (part == 1) ? m_req_valid[own] : 1'b0;
    exp_rdy  = (part == 1) ? (2'(bus_req_ready) << own) : 2'b00;
    exp_wv   = (part == 2) ? m_wvalid[own] : 1'b0;
    exp_wr   = (part == 2) ? (2'(bus_wready) << own) : 2'b00;
    exp_rv   = (part == 3) ? (2'(bus_rvalid) << own) : 2'b00;
    chk("busy", 64'(bus_busy), 64'(exp_busy));
    chk("req_valid", 64'(bus_req_valid), 64'(exp_rqv));
    chk("req_ready", 64'(m_req_ready), 64'(exp_rdy));
    if (exp_rqv) begin
      chk("req_addr", 64'(bus_req_addr), 64'(mst_addr[own]));
      chk("req_len", 64'(bus_req_len), 64'(mst_len[own]));
      chk("req_write", 64'(bus_req_write), 64'(mst_wr[own]));
    end
    chk("wvalid", 64'(bus_wvalid), 64'(exp_wv));
    chk("wready", 64'(m_wready), 64'(exp_wr));
    if (exp_wv) begin
      chk("wdata", 64'(bus_wdata), 64'(mst_wd[own]));
      chk("wlast", 64'(bus_wlast), 64'(mbeat == mlen));
    end
    chk("rvalid", 64'(m_rvalid), 64'(exp_rv));
    if (exp_rv != 2'b00) begin
      chk("rdata", 64'(m_rdata), 64'(bus_rdata));
      chk("rlast", 64'(m_rlast), 64'(bus_rlast));
    end
  endtask

  task automatic update_model();
    if (own < 0) begin
      if (m_req_valid != 2'b00) begin
`ifdef CACHE_BUS_ARB_RR_EN
        own = pick(m_req_valid, rr);
`else
        own = pick(m_req_valid, 0);
`endif
        part = 1;
      end
    end else if (part == 1) begin
      if (m_req_valid[own] && bus_req_ready) begin
        part = mst_wr[own] ? 2 : 3;
        mlen = int'(mst_len[own]);
        mbeat = 0;
      end
    end else if (part == 2) begin
      if (m_wvalid[own] && bus_wready) begin
        if (mbeat == mlen) begin rr = (own + 1) % 2; own = -1; part = 0; end
        else mbeat++;
      end
    end else if (part == 3) begin
      if (bus_rvalid && bus_rlast) begin rr = (own + 1) % 2; own = -1; part = 0; end
    end
  endtask

  task automatic update_stimulus();
    for (int i = 0; i < 2; i++) begin
      if (mst_st[i] == 1 && m_req_valid[i] && m_req_ready[i]) begin
        mst_st[i] = mst_wr[i] ? 2 : 3; mst_beat[i] = 0; mst_wv[i] = 1'b0;
      end else if (mst_st[i] == 2 && m_wvalid[i] && m_wready[i]) begin
        mst_wv[i] = 1'b0;
        mst_beat[i]++;
        if (mst_beat[i] == int'(mst_len[i]) + 1) begin mst_st[i] = 0; bursts_done++; end
      end else if (mst_st[i] == 3 && m_rvalid[i] && m_rlast) begin
        mst_st[i] = 0; bursts_done++;
      end
    end
    if (bus_rvalid) begin slv_left--; slv_rv = 1'b0; end
    if (bus_req_valid && bus_req_ready && !bus_req_write) slv_left = int'(bus_req_len) + 1;
  endtask

  initial begin
    rst_n = 1'b0;
    m_req_valid = '0; m_req_write = '0; m_req_addr = '0; m_req_len = '0;
    m_wdata = '0; m_wvalid = '0; bus_req_ready = 1'b0; bus_wready = 1'b0;
    bus_rdata = '0; bus_rvalid = 1'b0; bus_rlast = 1'b0;
    post_reset = 1'b0;
    reset_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 64'(ctrl), 64'd0);

    for (int ph = 0; ph < 3; ph++) begin
      req_pct = (ph == 0) ? 30 : (ph == 1) ? 100 : 60;
      rdy_pct = (ph == 0) ? 70 : (ph == 1) ? 50 : 100;
      for (int c = 0; c < 3000; c++) begin
        @(posedge clk);
        #1;
        rst_n = !(c > 20 && ($urandom % 400) == 0);
        drive();
        @(negedge clk);
        if (!rst_n) begin
          reset_all();
          post_reset = 1'b1;
        end else begin
          check_cycle();
          post_reset = 1'b0;
          update_model();
          update_stimulus();
        end
      end
    end

    chk("progress", 64'(bursts_done > 200), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
